// File: rtl/arbitro_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// rr_pick returns the first requester at or after ptr, wrapping modulo N_REQ.
package arbitro_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

  // Scans from the farthest offset down, so the nearest set bit after ptr wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction
endpackage

// File: rtl/decodificador.sv
// Binary-to-one-hot decoder with enable; q is all-zero when en is low.
module decodificador #(
  parameter int W = 3
) (
  input  logic [W-1:0]        d,
  input  logic                en,
  output logic [(1<<W)-1:0]   q
);
  for (genvar i = 0; i < (1 << W); i++) begin : g_q
    assign q[i] = en && (d == W'(i));
  end
endmodule

// File: rtl/arbitro_rr_dec.sv
// Round-robin arbiter for 8 requesters: the winner index drives a 3-to-8 decoder
// to form the one-hot grant; grants end on done, dropped req, or MAX_HOLD timeout.
module arbitro_rr_dec
  import arbitro_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             timeout
);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_t       state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx, idx_nx;
  logic [HW-1:0]    hold_cnt, hold_nx;
  logic             timeout_nx;
  logic             released, expired;

  assign released = done[gnt_idx] || !req[gnt_idx];
  assign expired  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    idx_nx     = gnt_idx;
    hold_nx    = hold_cnt;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          idx_nx   = rr_pick(req, ptr);
          hold_nx  = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (released || expired) begin
          state_nx   = RELEASE;
          ptr_nx     = gnt_idx + IDX_W'(1);
          hold_nx    = '0;
          // An owner release on the last allowed cycle suppresses the pulse.
          timeout_nx = expired && !released;
        end else begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      gnt_idx  <= idx_nx;
      hold_cnt <= hold_nx;
      timeout  <= timeout_nx;
    end
  end

  assign busy = (state == GRANT);

  decodificador #(.W(IDX_W)) u_dec (
    .d  (gnt_idx),
    .en (busy),
    .q  (gnt)
  );
endmodule

// File: tb/tb_arbitro_rr_dec.sv
// Bench for arbitro_rr_dec: directed scenarios plus random traffic, with a
// cycle-stamped event scoreboard fed by a behavioural arbiter model.
module tb_arbitro_rr_dec;
  localparam int MAX_HOLD = 16;
  localparam int EV_START = 0, EV_END = 1, EV_TO = 2;

  typedef struct {
    int kind;
    int owner;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] done = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: phase 0 = nobody owns, 1 = owner holds, 2 = mandatory gap cycle.
  int m_phase = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_hold = 0;
  ev_t exp_q[$];

  arbitro_rr_dec #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  always begin
    bit found, ended, expd;
    ev_t e;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
      exp_q.delete();
    end else begin
      cyc++;
      case (m_phase)
        0: if (req != 8'h00) begin
          found = 0;
          for (int k = 0; k < 8; k++)
            if (!found && req[(m_ptr + k) % 8]) begin
              m_owner = (m_ptr + k) % 8;
              found = 1;
            end
          m_hold = 0;
          m_phase = 1;
          e.kind = EV_START; e.owner = m_owner; e.cyc = cyc;
          exp_q.push_back(e);
        end
        1: begin
          ended = done[m_owner] || !req[m_owner];
          expd  = (MAX_HOLD != 0) && (m_hold == MAX_HOLD - 1);
          if (ended || expd) begin
            e.kind = EV_END; e.owner = m_owner; e.cyc = cyc;
            exp_q.push_back(e);
            if (expd && !ended) begin
              e.kind = EV_TO;
              exp_q.push_back(e);
            end
            m_ptr = (m_owner + 1) % 8;
            m_phase = 2;
          end else begin
            m_hold++;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Monitor: pops expected events due this cycle, flags missed or spurious ones.
  logic [7:0] prev_gnt = '0;
  always begin
    ev_t e;
    bit rise, fall, ms, me, mt;
    logic [7:0] exp_gnt;
    @(negedge clk);
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      rise = (gnt != 8'h00) && (prev_gnt == 8'h00);
      fall = (gnt == 8'h00) && (prev_gnt != 8'h00);
      ms = 0; me = 0; mt = 0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        tests++;
        if (e.cyc < cyc) begin
          fails++;
          $display("FAIL missed_event kind=%0d owner=%0d due=%0d now=%0d", e.kind, e.owner, e.cyc, cyc);
        end else if (e.kind == EV_START) begin
          ms = 1;
          if (!rise || gnt != (8'h01 << e.owner) || gnt_idx != 3'(e.owner)) begin
            fails++;
            $display("FAIL grant_start cyc=%0d gnt=%h idx=%0d expected gnt=%h idx=%0d",
                     cyc, gnt, gnt_idx, 8'h01 << e.owner, e.owner);
          end
        end else if (e.kind == EV_END) begin
          me = 1;
          if (!fall) begin
            fails++;
            $display("FAIL grant_end cyc=%0d gnt=%h expected 00 after owner %0d", cyc, gnt, e.owner);
          end
        end else begin
          mt = 1;
          if (timeout !== 1'b1 || gnt_idx != 3'(e.owner)) begin
            fails++;
            $display("FAIL timeout_pulse cyc=%0d timeout=%b idx=%0d expected 1 idx=%0d",
                     cyc, timeout, gnt_idx, e.owner);
          end
        end
      end
      tests++;
      if ((rise && !ms) || (fall && !me) || (timeout && !mt)) begin
        fails++;
        $display("FAIL spurious_event cyc=%0d rise=%b fall=%b timeout=%b expected none",
                 cyc, rise, fall, timeout);
      end
      exp_gnt = (m_phase == 1) ? (8'h01 << m_owner) : 8'h00;
      tests++;
      if (gnt !== exp_gnt || busy !== (m_phase == 1) || gnt_idx !== 3'(m_owner)) begin
        fails++;
        $display("FAIL cycle_state cyc=%0d gnt=%h busy=%b idx=%0d expected gnt=%h busy=%b idx=%0d",
                 cyc, gnt, busy, gnt_idx, exp_gnt, m_phase == 1, m_owner);
      end
      prev_gnt = gnt;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Returns at the first negedge with busy=1, or counts a failure.
  task automatic wait_busy(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (busy) ok = 1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_wait busy=0 expected 1 within 64 cycles", name);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = '0; done = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    // Reset with all requests active: outputs must be idle before any clock edge.
    req = 8'hFF;
    #3;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_idx", int'(gnt_idx), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_timeout", int'(timeout), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = '0;

    // Single request from ptr=0.
    @(posedge clk); #1 req = 8'h04;
    wait_busy("single");
    chk("single_gnt", int'(gnt), 8'h04);
    done = 8'h04;
    @(negedge clk); done = '0; req = '0;
    chk("single_release", int'(gnt), 0);

    // Fairness: every requester in turn, wrapping back to 0.
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      wait_busy("fair");
      chk("fair_owner", int'(gnt_idx), i % 8);
      done = 8'h01 << gnt_idx;
      @(negedge clk); done = '0;
    end
    req = '0;

    // Wrap: owner 5 leaves ptr=6, then 0 and 1 are served in order.
    do_reset();
    req = 8'h20;
    wait_busy("wrap5");
    chk("wrap_owner5", int'(gnt_idx), 5);
    done = 8'h20; req = '0;
    @(negedge clk); done = '0; req = 8'h03;
    wait_busy("wrap0");
    chk("wrap_gnt0", int'(gnt), 8'h01);
    done = 8'h01;
    @(negedge clk); done = '0;
    wait_busy("wrap1");
    chk("wrap_gnt1", int'(gnt), 8'h02);
    done = 8'h02;
    @(negedge clk); done = '0; req = '0;

    // Timeout: grant held exactly MAX_HOLD cycles, then a pulse.
    do_reset();
    req = 8'h08;
    wait_busy("to");
    n = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("to_hold_cycles", n, MAX_HOLD);
    chk("to_pulse", int'(timeout), 1);
    req = 8'h18;
    wait_busy("to_next");
    chk("to_next_owner", int'(gnt_idx), 4);
    req = '0;
    @(negedge clk);

    // Done on the final allowed cycle wins over the timeout.
    do_reset();
    req = 8'h08;
    wait_busy("to_done");
    repeat (MAX_HOLD - 1) @(negedge clk);
    chk("to_done_still_busy", int'(busy), 1);
    done = 8'h08;
    @(negedge clk); done = '0; req = '0;
    chk("to_done_no_pulse", int'(timeout), 0);
    chk("to_done_released", int'(busy), 0);

    // Async reset mid-grant clears outputs without a clock edge.
    do_reset();
    req = 8'h20;
    wait_busy("async");
    chk("async_gnt_before", int'(gnt), 8'h20);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", int'(gnt), 0);
    chk("async_busy", int'(busy), 0);
    @(posedge clk); #1;
    req = 8'h21; rst_n = 1'b1;
    wait_busy("async_after");
    chk("async_after_owner", int'(gnt_idx), 0);
    done = 8'h01;
    @(negedge clk); done = '0; req = '0;

    // Random traffic, alternating busy and sparse regimes.
    do_reset();
    for (int it = 0; it < 4000; it++) begin
      int r;
      bit slow;
      @(posedge clk); #1;
      slow = ((it / 500) % 2) == 1;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, slow ? 31 : 7) == 0) req[b] = ~req[b];
      r = $urandom_range(0, slow ? 39 : 9);
      if (r == 0) done = 8'h01 << gnt_idx;
      else if (r == 1) done = 8'($urandom);
      else done = '0;
    end
    @(posedge clk); #1 req = '0; done = '0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
